// File: rtl/dual_core_sum_sync.sv
// Lockstep controller for the cross-core partial-sum exchange: pops both sum FIFOs
// together, then runs the per-row normalization window and tracks job progress.
module dual_core_sum_sync #(
    parameter int ROW_W    = 5,
    parameter int NORM_CYC = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             err_clr,
    input  logic [ROW_W-1:0] num_rows,
    input  logic             core0_sum_valid,
    input  logic             core1_sum_valid,
    output logic             core0_fifo_rd,
    output logic             core1_fifo_rd,
    output logic             norm_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ROW_W-1:0] rows_done
);
    localparam int WCW = $clog2(TIMEOUT);
    localparam int NCW = (NORM_CYC > 1) ? $clog2(NORM_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XCHG,
        ST_NORM,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t           state_reg;
    logic [ROW_W-1:0] num_rows_reg;
    logic [ROW_W-1:0] rows_done_reg;
    logic [WCW-1:0]   wait_cnt_reg;
    logic [NCW-1:0]   norm_cnt_reg;
    logic [ROW_W-1:0] rows_done_next;
    logic             both_valid;

    assign rows_done_next = rows_done_reg + ROW_W'(1);
    assign both_valid     = core0_sum_valid & core1_sum_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            num_rows_reg  <= '0;
            rows_done_reg <= '0;
            wait_cnt_reg  <= '0;
            norm_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        num_rows_reg  <= num_rows;
                        rows_done_reg <= '0;
                        wait_cnt_reg  <= '0;
                        state_reg     <= (num_rows == '0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Exchange beats the timeout when both land on the final wait cycle
                    if (abort) begin
                        state_reg <= ST_IDLE;
                    end else if (both_valid) begin
                        state_reg <= ST_XCHG;
                    end else if (wait_cnt_reg == WCW'(TIMEOUT - 1)) begin
                        state_reg <= ST_ERR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WCW'(1);
                    end
                end
                ST_XCHG: begin
                    wait_cnt_reg <= '0;
                    norm_cnt_reg <= '0;
                    state_reg    <= abort ? ST_IDLE : ST_NORM;
                end
                ST_NORM: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                    end else if (norm_cnt_reg == NCW'(NORM_CYC - 1)) begin
                        rows_done_reg <= rows_done_next;
                        state_reg     <= (rows_done_next == num_rows_reg) ? ST_DONE : ST_WAIT;
                    end else begin
                        norm_cnt_reg <= norm_cnt_reg + NCW'(1);
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                ST_ERR: begin
                    if (err_clr) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Pure state decodes keep both pop strobes identical by construction
    assign core0_fifo_rd = (state_reg == ST_XCHG);
    assign core1_fifo_rd = (state_reg == ST_XCHG);
    assign norm_en       = (state_reg == ST_NORM);
    assign busy          = (state_reg == ST_WAIT) || (state_reg == ST_XCHG) || (state_reg == ST_NORM);
    assign done          = (state_reg == ST_DONE);
    assign err           = (state_reg == ST_ERR);
    assign rows_done     = rows_done_reg;

endmodule

// File: tb/tb_dual_core_sum_sync.sv
// Scoreboard bench for dual_core_sum_sync: expected rd/done/err events are queued
// with their cycle and rows_done, and a negedge monitor pops and compares them.
module tb_dual_core_sum_sync;
    localparam int ROW_W    = 5;
    localparam int NORM_CYC = 2;
    localparam int TIMEOUT  = 64;

    localparam int EV_RD   = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             err_clr = 1'b0;
    logic [ROW_W-1:0] num_rows = '0;
    logic             core0_sum_valid = 1'b0;
    logic             core1_sum_valid = 1'b0;
    logic             core0_fifo_rd;
    logic             core1_fifo_rd;
    logic             norm_en;
    logic             busy;
    logic             done;
    logic             err;
    logic [ROW_W-1:0] rows_done;

    typedef struct {
        int kind;
        int cyc;
        int rows;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fails = 0;
    logic err_prev = 1'b0;

    dual_core_sum_sync #(
        .ROW_W   (ROW_W),
        .NORM_CYC(NORM_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .err_clr        (err_clr),
        .num_rows       (num_rows),
        .core0_sum_valid(core0_sum_valid),
        .core1_sum_valid(core1_sum_valid),
        .core0_fifo_rd  (core0_fifo_rd),
        .core1_fifo_rd  (core1_fifo_rd),
        .norm_en        (norm_en),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .rows_done      (rows_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            EV_RD:   return "rd";
            EV_DONE: return "done";
            default: return "err";
        endcase
    endfunction

    task automatic push_ev(input int kind, input int c, input int rows);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.rows = rows;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int kind);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL unexpected_%s: got cyc=%0d rows=%0d, required no event", kind_name(kind), cyc, rows_done);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.rows != int'(rows_done)) begin
                n_fails++;
                $display("FAIL event_%s: got %s cyc=%0d rows=%0d, required %s cyc=%0d rows=%0d",
                         kind_name(e.kind), kind_name(kind), cyc, rows_done,
                         kind_name(e.kind), e.cyc, e.rows);
            end else begin
                $display("event %s cyc=%0d rows=%0d ok", kind_name(kind), cyc, rows_done);
            end
        end
    endtask

    // Monitor: one transaction per observed rd pulse, done pulse or err rise
    always @(negedge clk) begin
        if (core0_fifo_rd || core1_fifo_rd) begin
            n_checks++;
            if (core0_fifo_rd !== core1_fifo_rd) begin
                n_fails++;
                $display("FAIL rd_equal: got core0=%b core1=%b, required equal", core0_fifo_rd, core1_fifo_rd);
            end
            check_event(EV_RD);
        end
        if (done) check_event(EV_DONE);
        if (err && !err_prev) check_event(EV_ERR);
        err_prev <= err;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fails++;
            $display("FAIL %s: got %0d, required %0d", name, actual, expected);
        end else begin
            $display("check %s = %0d ok", name, actual);
        end
    endtask

    task automatic do_start(input int n, output int s);
        @(negedge clk);
        start    = 1'b1;
        num_rows = ROW_W'(n);
        s        = cyc;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int t;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_outputs", int'({core0_fifo_rd, core1_fifo_rd, norm_en, done, err}), 0);
        check("reset_rows_done", int'(rows_done), 0);
        reset = 1'b1;

        // Basic: 3 rows with valids held high
        core0_sum_valid = 1'b1;
        core1_sum_valid = 1'b1;
        do_start(3, s);
        push_ev(EV_RD, s + 2, 0);
        push_ev(EV_RD, s + 6, 1);
        push_ev(EV_RD, s + 10, 2);
        push_ev(EV_DONE, s + 13, 3);
        wait_until(s + 3);
        check("basic_norm_en", int'(norm_en), 1);
        wait_until(s + 14);
        check("basic_rows_done", int'(rows_done), 3);
        check("basic_busy_end", int'(busy), 0);

        // Skew: core1 arrives 5 cycles after core0
        core0_sum_valid = 1'b0;
        core1_sum_valid = 1'b0;
        do_start(1, s);
        t = cyc;
        core0_sum_valid = 1'b1;
        push_ev(EV_RD, t + 6, 0);
        push_ev(EV_DONE, t + 9, 1);
        repeat (5) @(negedge clk);
        core1_sum_valid = 1'b1;
        wait_until(t + 7);
        core0_sum_valid = 1'b0;
        core1_sum_valid = 1'b0;
        wait_until(t + 11);
        check("skew_rows_done", int'(rows_done), 1);

        // Timeout: no valids for the whole wait window
        do_start(2, s);
        push_ev(EV_ERR, s + 1 + TIMEOUT, 0);
        wait_until(s + 2 + TIMEOUT);
        check("timeout_err", int'(err), 1);
        check("timeout_busy", int'(busy), 0);
        start    = 1'b1;
        num_rows = ROW_W'(1);
        @(negedge clk);
        start    = 1'b0;
        @(negedge clk);
        check("err_ignores_start", int'(err), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr_err", int'(err), 0);
        check("err_clr_busy", int'(busy), 0);

        // Abort during NORM of row 2 of 4
        core0_sum_valid = 1'b1;
        core1_sum_valid = 1'b1;
        do_start(4, s);
        push_ev(EV_RD, s + 2, 0);
        push_ev(EV_RD, s + 6, 1);
        wait_until(s + 7);
        check("abort_in_norm", int'(norm_en), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_rows_done", int'(rows_done), 1);
        core0_sum_valid = 1'b0;
        core1_sum_valid = 1'b0;
        repeat (4) @(negedge clk);
        do_start(2, s);
        check("restart_rows_done", int'(rows_done), 0);
        check("restart_busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_wait_busy", int'(busy), 0);

        // Zero rows, then start pulses while busy
        do_start(0, s);
        push_ev(EV_DONE, s + 1, 0);
        repeat (2) @(negedge clk);
        core0_sum_valid = 1'b1;
        core1_sum_valid = 1'b1;
        do_start(2, s);
        push_ev(EV_RD, s + 2, 0);
        push_ev(EV_RD, s + 6, 1);
        push_ev(EV_DONE, s + 9, 2);
        wait_until(s + 3);
        start    = 1'b1;
        num_rows = ROW_W'(5);
        @(negedge clk);
        start    = 1'b0;
        wait_until(s + 10);
        check("ignored_start_rows", int'(rows_done), 2);

        // Reset asserted during the second exchange
        do_start(3, s);
        push_ev(EV_RD, s + 2, 0);
        push_ev(EV_RD, s + 6, 1);
        wait_until(s + 6);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", int'({core0_fifo_rd, core1_fifo_rd, norm_en, busy, done, err}), 0);
        check("rst_mid_rows_done", int'(rows_done), 0);
        reset = 1'b1;
        core0_sum_valid = 1'b0;
        core1_sum_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_mid_idle", int'(busy), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
